// File: rtl/i2c_pkg.sv
// Shared I2C constants: FSM state encoding, ACK/NACK levels, R/W bit values.
package i2c_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ADDR      = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK  = 3'd2;
    localparam logic [2:0] ST_WR_DATA   = 3'd3;
    localparam logic [2:0] ST_WR_ACK    = 3'd4;
    localparam logic [2:0] ST_RD_DATA   = 3'd5;
    localparam logic [2:0] ST_RD_ACK    = 3'd6;
    localparam logic [2:0] ST_WAIT_STOP = 3'd7;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        ADDR      = ST_ADDR,
        ADDR_ACK  = ST_ADDR_ACK,
        WR_DATA   = ST_WR_DATA,
        WR_ACK    = ST_WR_ACK,
        RD_DATA   = ST_RD_DATA,
        RD_ACK    = ST_RD_ACK,
        WAIT_STOP = ST_WAIT_STOP
    } i2c_state_e;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchroniser with SCL edge and START/STOP detection.
// The newer of the last two stages is the synchronised level; the older one
// is the previous sample used for edge detection.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic s_sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic s_scl, scl_q, sda_q;

    // Shift pin levels in; preset to idle-high so reset never fakes an edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
        end
    end

    assign s_scl = scl_sync[SYNC_STAGES-2];
    assign scl_q = scl_sync[SYNC_STAGES-1];
    assign s_sda = sda_sync[SYNC_STAGES-2];
    assign sda_q = sda_sync[SYNC_STAGES-1];

    assign scl_rise  =  s_scl & ~scl_q;
    assign scl_fall  = ~s_scl &  scl_q;
    // SDA moving while SCL is steadily high is a bus condition, not data
    assign start_det = s_scl & scl_q &  sda_q & ~s_sda;
    assign stop_det  = s_scl & scl_q & ~sda_q &  s_sda;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: address match, byte receive to fabric, byte transmit from fabric.
// Never stretches SCL; SDA is driven open-drain through sda_oe.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       busy,
    output logic       ack_error
);

    logic s_sda, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .s_sda     (s_sda),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_state_e state, state_d;
    logic [2:0] bit_cnt, bit_cnt_d;
    logic [7:0] shreg, shreg_d, rx_data_d;
    logic       rw, rw_d, sda_oe_d, rx_valid_d, tx_req_d, busy_d, ack_error_d;
    logic       byte_done, byte_done_d;   // 8th write bit just shifted in
    logic       ack_arm, ack_arm_d;       // first half of an ACK slot seen
    logic       ack_bit, ack_bit_d;       // ACK/NACK level for the WR_ACK slot

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            rw        <= RW_WRITE;
            sda_oe    <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            busy      <= 1'b0;
            ack_error <= 1'b0;
            byte_done <= 1'b0;
            ack_arm   <= 1'b0;
            ack_bit   <= I2C_ACK;
        end else begin
            bit_cnt   <= bit_cnt_d;
            shreg     <= shreg_d;
            rw        <= rw_d;
            sda_oe    <= sda_oe_d;
            rx_data   <= rx_data_d;
            rx_valid  <= rx_valid_d;
            tx_req    <= tx_req_d;
            busy      <= busy_d;
            ack_error <= ack_error_d;
            byte_done <= byte_done_d;
            ack_arm   <= ack_arm_d;
            ack_bit   <= ack_bit_d;
        end
    end

    // Next-state and output logic; bus START/STOP override every state
    always_comb begin
        state_d     = state;
        bit_cnt_d   = bit_cnt;
        shreg_d     = shreg;
        rw_d        = rw;
        sda_oe_d    = sda_oe;
        rx_data_d   = rx_data;
        rx_valid_d  = 1'b0;
        tx_req_d    = 1'b0;
        busy_d      = busy;
        ack_error_d = ack_error;
        byte_done_d = 1'b0;
        ack_arm_d   = ack_arm;
        ack_bit_d   = ack_bit;
        if (start_det || stop_det) begin
            state_d   = start_det ? ADDR : IDLE;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            ack_arm_d = 1'b0;
        end else begin
            case (state)
                ADDR: if (scl_rise) begin
                    shreg_d   = {shreg[6:0], s_sda};
                    bit_cnt_d = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (shreg[6:0] == SLAVE_ADDR) begin
                            state_d     = ADDR_ACK;
                            busy_d      = 1'b1;
                            ack_error_d = 1'b0;
                            rw_d        = s_sda ? RW_READ : RW_WRITE;
                            ack_arm_d   = 1'b0;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    if (!ack_arm) begin
                        sda_oe_d  = 1'b1;
                        ack_arm_d = 1'b1;
                    end else begin
                        ack_arm_d = 1'b0;
                        bit_cnt_d = '0;
                        if (rw == RW_WRITE) begin
                            sda_oe_d = 1'b0;
                            state_d  = WR_DATA;
                        end else begin
                            tx_req_d = 1'b1;
                            shreg_d  = tx_data;
                            sda_oe_d = ~tx_data[7];
                            state_d  = RD_DATA;
                        end
                    end
                end
                WR_DATA: if (byte_done) begin
                    ack_arm_d = 1'b0;
                    state_d   = WR_ACK;
                    if (rx_ready) begin
                        rx_data_d  = shreg;
                        rx_valid_d = 1'b1;
                        ack_bit_d  = I2C_ACK;
                    end else begin
                        ack_error_d = 1'b1;
                        ack_bit_d   = I2C_NACK;
                    end
                end else if (scl_rise) begin
                    shreg_d     = {shreg[6:0], s_sda};
                    bit_cnt_d   = bit_cnt + 3'd1;
                    byte_done_d = (bit_cnt == 3'd7);
                end
                WR_ACK: if (scl_fall) begin
                    if (!ack_arm) begin
                        sda_oe_d  = (ack_bit == I2C_ACK);
                        ack_arm_d = 1'b1;
                    end else begin
                        sda_oe_d  = 1'b0;
                        ack_arm_d = 1'b0;
                        state_d   = WR_DATA;
                    end
                end
                RD_DATA: if (scl_fall) begin
                    if (bit_cnt == 3'd7) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                        ack_arm_d = 1'b0;
                        state_d   = RD_ACK;
                    end else begin
                        bit_cnt_d = bit_cnt + 3'd1;
                        shreg_d   = {shreg[6:0], 1'b0};
                        sda_oe_d  = ~shreg[6];
                    end
                end
                RD_ACK: if (!ack_arm) begin
                    if (scl_rise) begin
                        if (s_sda == I2C_ACK) begin
                            ack_arm_d = 1'b1;
                        end else begin
                            state_d = WAIT_STOP;
                            busy_d  = 1'b0;
                        end
                    end
                end else if (scl_fall) begin
                    ack_arm_d = 1'b0;
                    tx_req_d  = 1'b1;
                    shreg_d   = tx_data;
                    sda_oe_d  = ~tx_data[7];
                    state_d   = RD_DATA;
                end
                default: sda_oe_d = 1'b0;   // IDLE, WAIT_STOP: bus released
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged open-drain master plus a transaction-level
// model of what the target should acknowledge, deliver and return.
module tb_i2c_slave;

    localparam int Q = 6;   // quarter SCL period in clk cycles

    logic       clk = 1'b0, rst = 1'b0;
    logic       scl_m = 1'b1, sda_m = 1'b1, rx_ready = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       sda_oe, rx_valid, tx_req, busy, ack_error, sda_line;
    logic [7:0] rx_data;

    int         n_chk = 0, n_err = 0, tx_cnt = 0;
    logic [7:0] rx_q[$];
    logic       m_err = 1'b0;   // model of the sticky ack_error

    assign sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_slave #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(3)) dut (
        .clk(clk), .rst(rst), .scl_in(scl_m), .sda_in(sda_line),
        .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .tx_req(tx_req), .tx_data(tx_data),
        .busy(busy), .ack_error(ack_error)
    );

    // Record fabric-side strobes
    always @(negedge clk) begin
        if (rx_valid) rx_q.push_back(rx_data);
        if (tx_req) tx_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    // Works both from idle and as a repeated START (SCL low on entry)
    task automatic start_c();
        sda_m = 1'b1; wq(); scl_m = 1'b1; wq(); sda_m = 1'b0; wq(); scl_m = 1'b0; wq();
    endtask

    task automatic stop_c();
        sda_m = 1'b0; wq(); scl_m = 1'b1; wq(); sda_m = 1'b1; wq(); wq();
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; wq(); scl_m = 1'b1; wq(); wq(); scl_m = 1'b0; wq();
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; wq(); scl_m = 1'b1; wq(); b = sda_line; wq(); scl_m = 1'b0; wq();
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack);
        logic a;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(a);
        ack = ~a;
    endtask

    // nxt is presented on tx_data before the master's ACK slot ends
    task automatic rd_byte(output logic [7:0] d, input logic mack, input logic [7:0] nxt);
        logic [7:0] t;
        logic       b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            t[i] = b;
        end
        d = t;
        tx_data = nxt;
        send_bit(~mack);
    endtask

    // One complete transaction checked against the model
    task automatic run_txn(input string nm, input logic [6:0] a, input logic rw, input int n,
                           input logic rdy, input logic [7:0] dv[4]);
        logic       match, ack;
        logic [7:0] d;
        logic [7:0] exp_rx[$];
        int         n0, t0;
        match = (a == 7'h50);
        n0 = rx_q.size();
        t0 = tx_cnt;
        rx_ready = rdy;
        tx_data = dv[0];
        start_c();
        wr_byte({a, rw}, ack);
        chk({nm, ".addr_ack"}, ack, match);
        chk({nm, ".busy_addr"}, busy, match);
        chk({nm, ".err_addr"}, ack_error, match ? 1'b0 : m_err);
        for (int i = 0; i < n; i++) begin
            if (!rw) begin
                wr_byte(dv[i], ack);
                chk($sformatf("%s.data_ack%0d", nm, i), ack, match & rdy);
                if (match && rdy) exp_rx.push_back(dv[i]);
            end else begin
                rd_byte(d, (i < n - 1), dv[i+1]);
                chk($sformatf("%s.rd%0d", nm, i), d, match ? dv[i] : 8'hFF);
            end
        end
        chk({nm, ".busy_end"}, busy, rw ? 1'b0 : match);
        stop_c();
        if (match) m_err = ~rw & ~rdy & (n > 0);
        chk({nm, ".busy_stop"}, busy, 0);
        chk({nm, ".ack_err"}, ack_error, m_err);
        chk({nm, ".rx_cnt"}, rx_q.size() - n0, exp_rx.size());
        for (int i = 0; i < exp_rx.size() && n0 + i < rx_q.size(); i++)
            chk($sformatf("%s.rx%0d", nm, i), rx_q[n0+i], exp_rx[i]);
        chk({nm, ".tx_cnt"}, tx_cnt - t0, (match && rw) ? n : 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] dv[4];
        logic [7:0] d;
        logic       ack, b;
        logic [6:0] a;
        int         n0, t0, w;

        repeat (4) @(negedge clk);
        chk("rst.sda_oe", sda_oe, 0);
        chk("rst.rx_data", rx_data, 0);
        chk("rst.rx_valid", rx_valid, 0);
        chk("rst.tx_req", tx_req, 0);
        chk("rst.busy", busy, 0);
        chk("rst.ack_error", ack_error, 0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        dv = '{8'h3C, 8'h00, 8'h00, 8'h00};
        run_txn("wr3c", 7'h50, 1'b0, 1, 1'b1, dv);
        run_txn("badaddr", 7'h51, 1'b0, 1, 1'b1, dv);
        dv = '{8'h5A, 8'hC3, 8'h00, 8'h00};
        run_txn("rd2", 7'h50, 1'b1, 2, 1'b1, dv);
        dv = '{8'h11, 8'h00, 8'h00, 8'h00};
        run_txn("nack", 7'h50, 1'b0, 1, 1'b0, dv);
        run_txn("clr_err", 7'h50, 1'b0, 1, 1'b1, dv);

        // Write then repeated START into a one-byte read
        n0 = rx_q.size();
        rx_ready = 1'b1;
        start_c();
        wr_byte(8'hA0, ack);
        wr_byte(8'h01, ack);
        chk("rs.wr_ack", ack, 1);
        tx_data = 8'h7E;
        start_c();
        wr_byte(8'hA1, ack);
        chk("rs.addr_ack", ack, 1);
        rd_byte(d, 1'b0, 8'h00);
        chk("rs.rd", d, 8'h7E);
        stop_c();
        chk("rs.rx_cnt", rx_q.size() - n0, 1);
        if (rx_q.size() > n0) chk("rs.rx", rx_q[n0], 8'h01);

        // Reset while the target drives a 0 on bit 3 of a read byte
        tx_data = 8'hF7;
        start_c();
        wr_byte(8'hA1, ack);
        for (int i = 0; i < 4; i++) recv_bit(b);
        w = 0;
        while (!sda_oe && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("mr.driving", sda_oe, 1);
        #2 rst = 1'b0;
        #1;
        chk("mr.sda_oe", sda_oe, 0);
        chk("mr.busy", busy, 0);
        chk("mr.rx_data", rx_data, 0);
        chk("mr.ack_error", ack_error, 0);
        m_err = 1'b0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        dv = '{8'h99, 8'h00, 8'h00, 8'h00};
        run_txn("after_rst", 7'h50, 1'b0, 1, 1'b1, dv);

        // Randomized transactions
        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(0, 1) == 0) a = 7'h50;
            else begin
                a = 7'($urandom_range(0, 127));
                if (a == 7'h50) a = 7'h2A;
            end
            for (int i = 0; i < 4; i++) dv[i] = 8'($urandom);
            run_txn($sformatf("rnd%0d", k), a, 1'($urandom), int'($urandom_range(1, 3)),
                    1'($urandom_range(0, 3) != 0), dv);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
